// File: rtl/router_out_ctrl.sv
// Output-port drain controller: reads framed entries from router_fifo, presents bytes with a
// valid/read handshake, checks trailing parity (ROUTER_PARITY_CHECK_EN) and flushes on a stall.
module router_out_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [8:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       soft_reset,
    output logic       vld_out,
    input  logic       read_enb,
    output logic [7:0] data_out,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       hdr_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state_r, state_s;
    logic [7:0] data_r, data_s;
    logic       vld_r, vld_s;
    logic       in_pkt_r, in_pkt_s;
    logic       hdr_pend_r, hdr_pend_s;
    logic [6:0] rem_r, rem_s;
    logic [7:0] tmo_r, tmo_s;
    logic       soft_reset_r, soft_reset_s;
    logic       pkt_done_r, pkt_done_s;
    logic       hdr_err_r, hdr_err_s;
    logic       rd_en_s;

    // Next-state, read strobe and next register values for the drain FSM.
    always_comb begin
        state_s      = state_r;
        data_s       = data_r;
        vld_s        = vld_r;
        in_pkt_s     = in_pkt_r;
        hdr_pend_s   = hdr_pend_r;
        rem_s        = rem_r;
        tmo_s        = 8'd0;
        soft_reset_s = 1'b0;
        pkt_done_s   = 1'b0;
        hdr_err_s    = 1'b0;
        rd_en_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                vld_s = 1'b0;
                // no read during reset or during the flush cycle, so nothing is lost
                if (!fifo_empty && !soft_reset_r && !reset) begin
                    rd_en_s = 1'b1;
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                data_s = fifo_data[7:0];
                if (fifo_data[8]) begin
                    hdr_err_s  = in_pkt_r;
                    in_pkt_s   = 1'b1;
                    hdr_pend_s = 1'b1;
                    rem_s      = {1'b0, fifo_data[7:2]} + 7'd1;
                    vld_s      = 1'b1;
                    state_s    = ST_PRESENT;
                end else if (!in_pkt_r) begin
                    hdr_err_s = 1'b1;
                    vld_s     = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    vld_s   = 1'b1;
                    state_s = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (read_enb) begin
                    hdr_pend_s = 1'b0;
                    vld_s      = 1'b0;
                    if (rem_r == 7'd0) begin
                        pkt_done_s = 1'b1;
                        in_pkt_s   = 1'b0;
                    end else begin
                        rem_s = rem_r - 7'd1;
                    end
                    if (!fifo_empty) begin
                        rd_en_s = 1'b1;
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    soft_reset_s = 1'b1;
                    vld_s        = 1'b0;
                    in_pkt_s     = 1'b0;
                    hdr_pend_s   = 1'b0;
                    rem_s        = 7'd0;
                    state_s      = ST_IDLE;
                end else begin
                    tmo_s = tmo_r + 8'd1;
                end
            end
            default: begin
                vld_s   = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            data_r       <= 8'h00;
            vld_r        <= 1'b0;
            in_pkt_r     <= 1'b0;
            hdr_pend_r   <= 1'b0;
            rem_r        <= 7'd0;
            tmo_r        <= 8'd0;
            soft_reset_r <= 1'b0;
            pkt_done_r   <= 1'b0;
            hdr_err_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            data_r       <= data_s;
            vld_r        <= vld_s;
            in_pkt_r     <= in_pkt_s;
            hdr_pend_r   <= hdr_pend_s;
            rem_r        <= rem_s;
            tmo_r        <= tmo_s;
            soft_reset_r <= soft_reset_s;
            pkt_done_r   <= pkt_done_s;
            hdr_err_r    <= hdr_err_s;
        end
    end

`ifdef ROUTER_PARITY_CHECK_EN
    function automatic logic [7:0] parity_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    logic [7:0] acc_r;
    logic       perr_r;
    logic       hdr_load_s, pay_acc_s, par_chk_s, abort_s;

    // The header is already in the accumulator when loaded, so its accept must not fold it again.
    assign hdr_load_s = (state_r == ST_LOAD) && fifo_data[8];
    assign pay_acc_s  = (state_r == ST_PRESENT) && read_enb && (rem_r != 7'd0) && !hdr_pend_r;
    assign par_chk_s  = (state_r == ST_PRESENT) && read_enb && (rem_r == 7'd0);
    assign abort_s    = (state_r == ST_PRESENT) && !read_enb && (tmo_r == TMO_LAST);

    // Running XOR of header and payload, compared against the parity byte on accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_r  <= 8'h00;
            perr_r <= 1'b0;
        end else begin
            perr_r <= 1'b0;
            if (hdr_load_s) begin
                acc_r <= fifo_data[7:0];
            end else if (pay_acc_s) begin
                acc_r <= parity_fold(acc_r, data_r);
            end else if (par_chk_s) begin
                perr_r <= (data_r != acc_r);
                acc_r  <= 8'h00;
            end else if (abort_s) begin
                acc_r <= 8'h00;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign parity_err = perr_r;
`else
    assign parity_err = 1'b0;
`endif

    assign fifo_rd_en = rd_en_s;
    assign soft_reset = soft_reset_r;
    assign vld_out    = vld_r;
    assign data_out   = data_r;
    assign pkt_done   = pkt_done_r;
    assign hdr_err    = hdr_err_r;

endmodule

// File: tb/tb_router_out_ctrl.sv
// Directed bench for router_out_ctrl with a small FIFO model feeding it; honours ROUTER_PARITY_CHECK_EN.
module tb_router_out_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [8:0] fifo_data = 9'h000;
    logic       fifo_rd_en;
    logic       soft_reset;
    logic       vld_out;
    logic       read_enb;
    logic [7:0] data_out;
    logic       pkt_done;
    logic       parity_err;
    logic       hdr_err;

    int n_assert = 0;
    int n_fail   = 0;
    int hdr_cnt  = 0;
    int done_cnt = 0;

`ifdef ROUTER_PARITY_CHECK_EN
    localparam logic PERR_EXP = 1'b1;
`else
    localparam logic PERR_EXP = 1'b0;
`endif

    router_out_ctrl #(.TIMEOUT(30)) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .soft_reset (soft_reset),
        .vld_out    (vld_out),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .hdr_err    (hdr_err)
    );

    always #5 clock = ~clock;

    // FIFO model: data appears the cycle after the read strobe; soft_reset flushes it.
    logic [8:0] fmem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clock) begin
        if (soft_reset) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= fmem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] e);
        fmem[wr_ptr[7:0]] = e;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic wait_vld(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!vld_out && n < 20) begin
            tick;
            n++;
            hdr_cnt  += int'(hdr_err);
            done_cnt += int'(pkt_done);
        end
        chk({tag, "_lat"}, n, exp_lat);
    endtask

    task automatic accept(input string tag, input logic [7:0] exp_d, input logic exp_done,
                          input logic exp_perr);
        chk({tag, "_vld"}, vld_out, 1);
        chk({tag, "_data"}, data_out, exp_d);
        read_enb = 1'b1;
        tick;
        read_enb = 1'b0;
        chk({tag, "_done"}, pkt_done, exp_done);
        chk({tag, "_perr"}, parity_err, exp_perr);
        chk({tag, "_vlddrop"}, vld_out, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_sr;
        int sr_cnt;
        reset    = 1'b1;
        read_enb = 1'b0;

        // Reset with a whole packet waiting; 0D^11^22^33 = 0D
        push(9'h10D); push(9'h011); push(9'h022); push(9'h033); push(9'h00D);
        repeat (3) tick;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_vld", vld_out, 0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_soft", soft_reset, 0);
        chk("rst_done", pkt_done, 0);
        chk("rst_hdr", hdr_err, 0);
        chk("rst_perr", parity_err, 0);
        reset = 1'b0;
        #1;
        chk("rel_rd_en", fifo_rd_en, 1);
        tick;
        chk("rel_vld0", vld_out, 0);
        tick;

        // Streaming, destination always ready: one byte every two cycles
        accept("p1h", 8'h0D, 1'b0, 1'b0);
        wait_vld("p1b1", 1); accept("p1b1", 8'h11, 1'b0, 1'b0);
        wait_vld("p1b2", 1); accept("p1b2", 8'h22, 1'b0, 1'b0);
        wait_vld("p1b3", 1); accept("p1b3", 8'h33, 1'b0, 1'b0);
        wait_vld("p1p", 1);  accept("p1p", 8'h0D, 1'b1, 1'b0);
        tick;
        chk("p1_done_pulse", pkt_done, 0);
        chk("p1_idle_rd", fifo_rd_en, 0);

        // Same packet with a bad parity byte
        push(9'h10D); push(9'h011); push(9'h022); push(9'h033); push(9'h0FF);
        wait_vld("p2h", 2);  accept("p2h", 8'h0D, 1'b0, 1'b0);
        wait_vld("p2b1", 1); accept("p2b1", 8'h11, 1'b0, 1'b0);
        wait_vld("p2b2", 1); accept("p2b2", 8'h22, 1'b0, 1'b0);
        wait_vld("p2b3", 1); accept("p2b3", 8'h33, 1'b0, 1'b0);
        wait_vld("p2p", 1);  accept("p2p", 8'hFF, 1'b1, PERR_EXP);

        // Destination stalls on the header: timeout flushes
        push(9'h10D); push(9'h011);
        wait_vld("to", 2);
        first_sr = 0;
        sr_cnt   = 0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (i == 29) begin
                chk("to_vld_held", vld_out, 1);
                chk("to_data_held", data_out, 8'h0D);
            end
            if (soft_reset) begin
                sr_cnt++;
                if (first_sr == 0) first_sr = i;
                chk("to_sr_rd_en", fifo_rd_en, 0);
                chk("to_sr_vld", vld_out, 0);
            end
        end
        chk("to_first", first_sr, 30);
        chk("to_count", sr_cnt, 1);
        chk("to_end_vld", vld_out, 0);
        chk("to_flushed", fifo_empty, 1);
        chk("to_end_rd", fifo_rd_en, 0);

        // Stray payload byte before a header; then L=0 packet 01, parity 01
        hdr_cnt  = 0;
        done_cnt = 0;
        push(9'h0AA); push(9'h101); push(9'h001);
        wait_vld("he", 4);
        chk("he_hdr_cnt", hdr_cnt, 1);
        accept("he_h", 8'h01, 1'b0, 1'b0);
        wait_vld("he_p", 1); accept("he_p", 8'h01, 1'b1, 1'b0);
        chk("he_done_cnt", done_cnt, 0);

        // Header arrives mid-packet: resync onto new packet 05, 22, parity 27
        hdr_cnt  = 0;
        done_cnt = 0;
        push(9'h10D); push(9'h011); push(9'h105); push(9'h022); push(9'h027);
        wait_vld("rs0", 2);  accept("rs0", 8'h0D, 1'b0, 1'b0);
        wait_vld("rs1", 1);  accept("rs1", 8'h11, 1'b0, 1'b0);
        wait_vld("rsh", 1);
        chk("rs_hdr_cnt", hdr_cnt, 1);
        chk("rs_hdr_now", hdr_err, 1);
        accept("rsh", 8'h05, 1'b0, 1'b0);
        wait_vld("rsb", 1);  accept("rsb", 8'h22, 1'b0, 1'b0);
        wait_vld("rsp", 1);  accept("rsp", 8'h27, 1'b1, 1'b0);
        chk("rs_done_cnt", done_cnt, 0);
        tick;
        chk("rs_end_vld", vld_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
